// File: rtl/hs_elastic_fifo.sv
// Valid/ready elastic FIFO with registered ready, valid, data, count and almost-full.
// The head entry lives in o_data_q; the circular array holds every entry, including the head.
module hs_elastic_fifo #(
   parameter int DWIDTH    = 8,
   parameter int DEPTH     = 4,
   parameter int AFULL_LVL = DEPTH - 1,
   parameter int CWIDTH    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [DWIDTH-1:0] i_data,
   input  logic              i_valid,
   output logic              i_ready,
   output logic [DWIDTH-1:0] o_data,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [CWIDTH-1:0] o_count,
   output logic              o_afull
);

   localparam int PWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [PWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PWIDTH-1:0] wr_next, rd_next;
   logic [CWIDTH-1:0] count_q, count_d;
   logic [DWIDTH-1:0] o_data_q, o_data_d;
   logic              o_valid_q, o_valid_d;
   logic              i_ready_q, i_ready_d;
   logic              o_afull_q, o_afull_d;
   logic              push, pop;

   assign push    = i_valid && i_ready_q;
   assign pop     = o_valid_q && o_ready;
   assign wr_next = (wr_ptr_q == PWIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + PWIDTH'(1);
   assign rd_next = (rd_ptr_q == PWIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + PWIDTH'(1);

   always_comb begin
      wr_ptr_d = push ? wr_next : wr_ptr_q;
      rd_ptr_d = pop  ? rd_next : rd_ptr_q;
      count_d  = count_q + CWIDTH'(push) - CWIDTH'(pop);
      o_data_d = o_data_q;
      // A new head comes from the array, or from i_data when the slot it needs is being written now.
      if (pop) begin
         if (count_q == CWIDTH'(1)) begin
            if (push) o_data_d = i_data;
         end else begin
            o_data_d = mem_q[rd_next];
         end
      end else if (push && count_q == '0) begin
         o_data_d = i_data;
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         o_data_d = o_data_q;
      end
      o_valid_d = (count_d != '0);
      i_ready_d = (count_d < CWIDTH'(DEPTH));
      o_afull_d = (count_d >= CWIDTH'(AFULL_LVL));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         i_ready_q <= 1'b0;
         o_afull_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         o_data_q  <= o_data_d;
         o_valid_q <= o_valid_d;
         i_ready_q <= i_ready_d;
         o_afull_q <= o_afull_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem_q[wr_ptr_q] <= i_data;
   end

   assign i_ready = i_ready_q;
   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_count = count_q;
   assign o_afull = o_afull_q;

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Directed vector table plus streaming, stall and randomised DEPTH=3 scoreboard checks.
module tb_hs_elastic_fifo;

   logic       clk = 1'b0;
   logic       rst, flush, i_valid, o_ready;
   logic [7:0] i_data;
   logic       i_ready, o_valid, o_afull;
   logic [7:0] o_data;
   logic [2:0] o_count;

   logic       flush3, iv3, or3, ir3, ov3, af3;
   logic [7:0] id3, od3;
   logic [1:0] cnt3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hs_elastic_fifo #(.DWIDTH(8), .DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .i_data(i_data), .i_valid(i_valid),
      .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
      .o_count(o_count), .o_afull(o_afull)
   );

   hs_elastic_fifo #(.DWIDTH(8), .DEPTH(3)) u_dut3 (
      .clk(clk), .rst(rst), .flush(flush3), .i_data(id3), .i_valid(iv3),
      .i_ready(ir3), .o_data(od3), .o_valid(ov3), .o_ready(or3),
      .o_count(cnt3), .o_afull(af3)
   );

   typedef struct {
      logic       rst, flush, iv;
      logic [7:0] id;
      logic       ordy;
      logic       ir, ov;
      logic [7:0] od;
      logic [2:0] cnt;
      logic       af;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic f, logic iv, logic [7:0] id, logic ordy,
                               logic ir, logic ov, logic [7:0] od, logic [2:0] cnt, logic af);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
      v.ir = ir; v.ov = ov; v.od = od; v.cnt = cnt; v.af = af;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic drive(logic r, logic f, logic iv, logic [7:0] id, logic ordy);
      @(negedge clk);
      rst = r; flush = f; i_valid = iv; i_data = id; o_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int q3[$];
      logic p3, pp3;
      rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i_data = 8'h00; o_ready = 1'b0;
      flush3 = 1'b0; iv3 = 1'b0; or3 = 1'b0; id3 = 8'h00;

      //             rst flush iv  id     ordy  ir  ov  od     cnt af
      vecs.push_back(mk(1, 0, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8'hA0, 0,   1, 1, 8'hA0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 8'hA1, 0,   1, 1, 8'hA0, 2, 0));
      vecs.push_back(mk(0, 0, 1, 8'hA2, 0,   1, 1, 8'hA0, 3, 1));
      vecs.push_back(mk(0, 0, 1, 8'hA3, 0,   0, 1, 8'hA0, 4, 1));
      vecs.push_back(mk(0, 0, 1, 8'hA4, 0,   0, 1, 8'hA0, 4, 1));
      vecs.push_back(mk(0, 0, 1, 8'hA4, 1,   1, 1, 8'hA1, 3, 1));
      vecs.push_back(mk(0, 0, 1, 8'hA4, 1,   1, 1, 8'hA2, 3, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 1, 8'hA3, 2, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 1, 8'hA4, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 0, 8'hA4, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0,   1, 0, 8'hA4, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8'hB0, 0,   1, 1, 8'hB0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 8'hB1, 0,   1, 1, 8'hB0, 2, 0));
      vecs.push_back(mk(0, 0, 1, 8'hB2, 0,   1, 1, 8'hB0, 3, 1));
      vecs.push_back(mk(0, 1, 1, 8'hB3, 1,   1, 0, 8'hB0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8'h55, 0,   1, 1, 8'h55, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 0, 8'h55, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0,   1, 0, 8'h55, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8'hC0, 0,   1, 1, 8'hC0, 1, 0));
      vecs.push_back(mk(1, 0, 1, 8'hC1, 1,   0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8'hD0, 0,   1, 1, 8'hD0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 8'hD1, 1,   1, 1, 8'hD1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 0, 8'hD1, 0, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
         checks++;
         if ({i_ready, o_valid, o_data, o_count, o_afull} !==
             {vecs[i].ir, vecs[i].ov, vecs[i].od, vecs[i].cnt, vecs[i].af}) begin
            errors++;
            $display("FAIL vec%0d got ir=%0b ov=%0b od=%h cnt=%0d af=%0b want ir=%0b ov=%0b od=%h cnt=%0d af=%0b",
                     i, i_ready, o_valid, o_data, o_count, o_afull,
                     vecs[i].ir, vecs[i].ov, vecs[i].od, vecs[i].cnt, vecs[i].af);
         end
         $display("vec %0d ir=%0b ov=%0b od=%h cnt=%0d af=%0b", i, i_ready, o_valid, o_data, o_count, o_afull);
      end

      // Streaming: one transfer per cycle, head follows the input one edge later.
      for (int k = 1; k <= 32; k++) begin
         drive(1'b0, 1'b0, 1'b1, 8'(k), 1'b1);
         check($sformatf("stream_od%0d", k), {24'h0, o_data}, 32'(k));
         check($sformatf("stream_ov_cnt%0d", k), {28'h0, o_valid, o_count}, {28'h0, 1'b1, 3'd1});
         $display("stream %0d od=%h cnt=%0d", k, o_data, o_count);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("stream_drain", {28'h0, o_valid, o_count}, 32'h0);

      // Stall: head must hold while offered pushes fill the buffer.
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 1'b1, 8'hE0 + 8'(k), 1'b0);
         check($sformatf("stall_hold%0d", k), {23'h0, o_valid, o_data}, {23'h0, 1'b1, 8'hE0});
         $display("stall %0d od=%h cnt=%0d", k, o_data, o_count);
      end
      check("stall_cnt", {29'h0, o_count}, 32'd4);
      for (int k = 1; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
         check($sformatf("resume%0d", k), {23'h0, o_valid, o_data}, {23'h0, 1'b1, 8'hE0 + 8'(k)});
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("resume_empty", {31'h0, o_valid}, 32'h0);

      // Randomised DEPTH=3 run against a queue scoreboard.
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         iv3 = 1'($urandom_range(0, 1));
         or3 = 1'($urandom_range(0, 1));
         id3 = 8'($urandom);
         p3  = iv3 && ir3;
         pp3 = ov3 && or3;
         if (pp3) begin
            if (q3.size() == 0) begin
               checks++; errors++;
               $display("FAIL rand_underflow cycle %0d", c);
            end else begin
               check($sformatf("rand_pop%0d", c), {24'h0, od3}, {24'h0, 8'(q3[0])});
               void'(q3.pop_front());
            end
         end
         if (p3) q3.push_back(int'(id3));
         @(posedge clk);
         #1;
         check($sformatf("rand_cnt%0d", c), {30'h0, cnt3}, 32'(q3.size()));
         if (c % 100 == 0) $display("rand %0d cnt=%0d od=%h", c, cnt3, od3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
